// File: rtl/sled_pkg.sv
// Shared types and constants for the 4-digit 7-seg scan driver.
// Holds the slot state enum, digit count, all-off enable pattern and default timing.
// No ports; imported by sled_scan and sled_lz_mask.
package sled_pkg;

   typedef enum logic {S_ON, S_GAP} state_e;

   localparam int         NDIG    = 4;
   localparam logic [3:0] DIG_OFF = 4'b1111;
   localparam int         DIV_DEF = 50000;
   localparam int         GAP_DEF = 500;

endpackage

// File: rtl/sled_lz_mask.sv
// Leading-zero blank mask: marks which digits are dark when blanking is enabled.
// Ports: snap_i (displayed 16-bit value), lzb_i (blank enable) -> blank_o[k]=1 hides digit k.
// Purely combinational; digit 0 is never blanked so a zero value still shows "0".
module sled_lz_mask
   import sled_pkg::*;
(
   input  logic [15:0]     snap_i,
   input  logic            lzb_i,
   output logic [NDIG-1:0] blank_o
);

   // Digit k is a leading zero when every nibble from k upward is zero.
   always_comb begin
      blank_o    = '0;
      blank_o[1] = lzb_i && (snap_i[15:4]  == 12'h000);
      blank_o[2] = lzb_i && (snap_i[15:8]  == 8'h00);
      blank_o[3] = lzb_i && (snap_i[15:12] == 4'h0);
   end

endmodule

// File: rtl/sled_scan.sv
// Digit-scan driver: snapshots DIN on LOAD, commits at frame boundaries, walks digits 0..3
// with an all-off gap between slots. Ports: CLK50M/RST_N (sync active-low), DIN/LOAD/LZB in;
// QT (nibble), DIG_N (active-low enables), FRAME (boundary pulse) out, all registered.
module sled_scan
   import sled_pkg::*;
#(
   parameter int DIV = DIV_DEF,
   parameter int GAP = GAP_DEF
)
(
   input  logic        CLK50M,
   input  logic        RST_N,
   input  logic [15:0] DIN,
   input  logic        LOAD,
   input  logic        LZB,
   output logic [3:0]  QT,
   output logic [3:0]  DIG_N,
   output logic        FRAME
);

   localparam int             MAXC   = (DIV > GAP) ? DIV : GAP;
   localparam int             CW     = $clog2(MAXC);
   localparam logic [CW-1:0]  DIV_M1 = CW'(DIV - 1);
   localparam logic [CW-1:0]  GAP_M1 = CW'((GAP > 0) ? GAP - 1 : 0);

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            run_q, run_d;
   logic [15:0]     snap_q, snap_d;
   logic [15:0]     shadow_q, shadow_d;
   logic            pend_q, pend_d;
   logic [3:0]      qt_q, qt_d;
   logic [3:0]      dig_q, dig_d;
   logic            frame_q, frame_d;
   logic            boundary;
   logic [NDIG-1:0] blank;

   // Slot sequencing and snapshot commit. Outputs are registered from the next
   // state, so run_q holds the first post-reset cycle at ON/idx0/cnt0.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      run_d    = 1'b1;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      snap_d   = snap_q;
      if (run_q) begin
         case (state_q)
            S_ON: begin
               if (cnt_q == DIV_M1) begin
                  cnt_d = '0;
                  if (GAP == 0) idx_d = idx_q + 2'd1;
                  else          state_d = S_GAP;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_M1) begin
                  cnt_d   = '0;
                  idx_d   = idx_q + 2'd1;
                  state_d = S_ON;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = S_ON;
         endcase
      end
      // Digit index only moves on a slot change, so 3->0 marks the frame start.
      boundary = run_q && (idx_q == 2'd3) && (idx_d == 2'd0);
      if (LOAD) begin
         shadow_d = DIN;
         pend_d   = 1'b1;
      end
      if (boundary) begin
         // A load landing on the boundary bypasses the shadow for this frame.
         if (LOAD) begin
            snap_d = DIN;
            pend_d = 1'b0;
         end else if (pend_q) begin
            snap_d = shadow_q;
            pend_d = 1'b0;
         end
      end
   end

   sled_lz_mask u_lz_mask (
      .snap_i  (snap_d),
      .lzb_i   (LZB),
      .blank_o (blank)
   );

   // Output values use the freshly committed snapshot, so a new frame shows
   // the new value from its very first cycle.
   always_comb begin
      dig_d   = DIG_OFF;
      qt_d    = qt_q;
      frame_d = boundary;
      if (state_d == S_ON) begin
         qt_d = snap_d[{idx_d, 2'b00} +: 4];
         if (!blank[idx_d]) dig_d = ~(4'b0001 << idx_d);
      end
   end

   always_ff @(posedge CLK50M) begin
      if (!RST_N) begin
         state_q  <= S_ON;
         idx_q    <= 2'd0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         snap_q   <= 16'h0000;
         shadow_q <= 16'h0000;
         pend_q   <= 1'b0;
         qt_q     <= 4'h0;
         dig_q    <= DIG_OFF;
         frame_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         snap_q   <= snap_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         qt_q     <= qt_d;
         dig_q    <= dig_d;
         frame_q  <= frame_d;
      end
   end

   assign QT    = qt_q;
   assign DIG_N = dig_q;
   assign FRAME = frame_q;

endmodule

// File: tb/tb_sled_scan.sv
module tb_sled_scan;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din = 16'h0000;
   logic        load = 1'b0;
   logic        lzb = 1'b0;
   logic [3:0]  qt_a, dig_a, qt_b, dig_b;
   logic        frame_a, frame_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // Instance A: DIV=4 GAP=1 (slot 5, frame 20). Instance B: DIV=4 GAP=0 (frame 16).
   sled_scan #(.DIV(DIV), .GAP(1)) u_dut_a (
      .CLK50M(clk), .RST_N(rst_n), .DIN(din), .LOAD(load), .LZB(lzb),
      .QT(qt_a), .DIG_N(dig_a), .FRAME(frame_a)
   );
   sled_scan #(.DIV(DIV), .GAP(0)) u_dut_b (
      .CLK50M(clk), .RST_N(rst_n), .DIN(din), .LOAD(load), .LZB(lzb),
      .QT(qt_b), .DIG_N(dig_b), .FRAME(frame_b)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          m_t = -1;      // display cycle index since reset release
   bit          m_run = 0;
   bit          m_ok = 0;
   bit          m_lzb = 0;
   logic [15:0] m_snap [2];
   logic [15:0] m_shadow [2];
   bit          m_pend [2];

   function automatic int gap_of(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   function automatic bit is_frame(input int i, input int t);
      int slot = DIV + gap_of(i);
      return (t > 0) && (t % (4 * slot) == 0);
   endfunction

   function automatic int digit_of(input int i, input int t);
      return (t / (DIV + gap_of(i))) % 4;
   endfunction

   function automatic bit lit_of(input int i, input int t);
      return (t % (DIV + gap_of(i))) < DIV;
   endfunction

   always @(posedge clk) begin
      m_ok = 1;
      if (!rst_n) begin
         m_run = 0;
         m_t   = -1;
         for (int i = 0; i < 2; i++) begin
            m_snap[i] = 16'h0; m_shadow[i] = 16'h0; m_pend[i] = 0;
         end
      end else begin
         m_t   = m_run ? m_t + 1 : 0;
         m_run = 1;
         m_lzb = lzb;
         for (int i = 0; i < 2; i++) begin
            if (load) begin m_shadow[i] = din; m_pend[i] = 1; end
            if (is_frame(i, m_t)) begin
               if (load)           begin m_snap[i] = din;         m_pend[i] = 0; end
               else if (m_pend[i]) begin m_snap[i] = m_shadow[i]; m_pend[i] = 0; end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         for (int i = 0; i < 2; i++) begin
            logic [3:0] e_qt, e_dig, a_qt, a_dig;
            logic       e_fr, a_fr;
            int         d;
            a_qt  = (i == 0) ? qt_a : qt_b;
            a_dig = (i == 0) ? dig_a : dig_b;
            a_fr  = (i == 0) ? frame_a : frame_b;
            if (!m_run) begin
               e_qt = 4'h0; e_dig = 4'hF; e_fr = 1'b0;
            end else begin
               d     = digit_of(i, m_t);
               e_qt  = 4'((m_snap[i] >> (4 * d)) & 16'hF);
               e_fr  = is_frame(i, m_t);
               e_dig = 4'hF;
               if (lit_of(i, m_t) && !(m_lzb && d > 0 && (m_snap[i] >> (4 * d)) == 0))
                  e_dig = ~(4'b0001 << d);
            end
            chk(i == 0 ? "A.qt" : "B.qt", 16'(a_qt), 16'(e_qt));
            chk(i == 0 ? "A.dig_n" : "B.dig_n", 16'(a_dig), 16'(e_dig));
            chk(i == 0 ? "A.frame" : "B.frame", 16'(a_fr), 16'(e_fr));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Waits (at negedges) until the outputs show display cycle T.
   task automatic wait_t(input int T);
      int n = 0;
      while (m_t != T && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (m_t != T) begin
         n_chk++;
         $display("FAIL wait_t: cycle %0d not reached, at %0d", T, m_t);
      end
   endtask

   // LOAD is sampled on the edge that produces display cycle T.
   task automatic load_at(input int T, input logic [15:0] v);
      wait_t(T - 1);
      load = 1'b1;
      din  = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.dig_n", 16'(dig_a), 16'hF);
      chk("rst.qt", 16'(qt_a), 16'h0);
      chk("rst.frame", 16'(frame_a), 16'h0);
      rst_n = 1'b1;

      // Scan pattern and first frame pulse.
      wait_t(0);  chk("t0.dig_n", 16'(dig_a), 16'hE);
      wait_t(4);  chk("t4.dig_n", 16'(dig_a), 16'hF);
                  chk("B.t4.dig_n", 16'(dig_b), 16'hD);
      wait_t(5);  chk("t5.dig_n", 16'(dig_a), 16'hD);
      load_at(7, 16'h1234);
      wait_t(12); chk("B.t12.dig_n", 16'(dig_b), 16'h7);
      wait_t(15); chk("pre.qt", 16'(qt_a), 16'h0);
      wait_t(16); chk("B.frame16", 16'(frame_b), 16'h1);
                  chk("B.t16.qt", 16'(qt_b), 16'h4);
      wait_t(19); chk("t19.frame", 16'(frame_a), 16'h0);
      wait_t(20); chk("frame20", 16'(frame_a), 16'h1);
                  chk("t20.qt", 16'(qt_a), 16'h4);
      wait_t(25); chk("t25.qt", 16'(qt_a), 16'h3);
      wait_t(30); chk("t30.qt", 16'(qt_a), 16'h2);
      wait_t(35); chk("t35.qt", 16'(qt_a), 16'h1);
                  chk("t35.dig_n", 16'(dig_a), 16'h7);

      // Leading-zero blanking.
      wait_t(38); lzb = 1'b1;
      load_at(41, 16'h0005);
      wait_t(60); chk("lz5.dig0", 16'(dig_a), 16'hE);
                  chk("lz5.qt", 16'(qt_a), 16'h5);
      load_at(62, 16'h0000);
      wait_t(65); chk("lz5.dig1", 16'(dig_a), 16'hF);
      wait_t(80); chk("lz0.dig0", 16'(dig_a), 16'hE);
                  chk("lz0.qt", 16'(qt_a), 16'h0);
      load_at(82, 16'h0105);
      wait_t(85); chk("lz0.dig1", 16'(dig_a), 16'hF);
      wait_t(110); chk("lz105.dig2", 16'(dig_a), 16'hB);
      wait_t(115); chk("lz105.dig3", 16'(dig_a), 16'hF);
      lzb = 1'b0;

      // Last load in a frame wins; load on the boundary edge takes effect at once.
      load_at(122, 16'hAAAA);
      load_at(125, 16'hBBBB);
      wait_t(140); chk("lastwins.qt", 16'(qt_a), 16'hB);
      load_at(160, 16'hCCCC);
      chk("bypass.qt", 16'(qt_a), 16'hC);
      chk("bypass.frame", 16'(frame_a), 16'h1);
      wait_t(175); chk("bypass.qt3", 16'(qt_a), 16'hC);

      // One-cycle reset during the gap after digit 2.
      wait_t(193);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst.dig_n", 16'(dig_a), 16'hF);
      chk("midrst.qt", 16'(qt_a), 16'h0);
      chk("midrst.frame", 16'(frame_a), 16'h0);
      rst_n = 1'b1;
      wait_t(0);  chk("rel.dig_n", 16'(dig_a), 16'hE);
      wait_t(10); chk("rel.qt", 16'(qt_a), 16'h0);
                  chk("rel.dig2", 16'(dig_a), 16'hB);
      load_at(13, 16'h9876);
      wait_t(45);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
